// File: rtl/wb_cpu_master.sv
// Single-outstanding CPU-to-Wishbone bridge. Load/store done pulse 3 cycles after req with a 1-cycle-ack slave.
// Backpressure: wb_stall holds stb in REQ; cpu_busy blocks new requests until DONE; watchdog aborts hung cycles.
module wb_cpu_master #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_dat_w,
    output logic          cpu_busy,
    output logic          cpu_done,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_dat_r,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [AW-1:0] wb_adr,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack,
    input  logic          wb_err,
    input  logic          wb_stall
);

    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the edge where the counter would reach TIMEOUT, so cyc spans exactly TIMEOUT cycles.
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [WDW-1:0]  r_wd;
    logic            r_cyc, r_stb, r_we, r_busy, r_done, r_err;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat_o, r_dat_r;
    logic            w_expire;

    assign w_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wd    <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat_o <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_dat_r <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (cpu_req) begin
                        r_state <= S_REQ;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_we    <= cpu_we;
                        r_adr   <= cpu_adr;
                        r_dat_o <= cpu_dat_w;
                        r_wd    <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (wb_err || wb_ack || w_expire) begin
                        r_state <= S_DONE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= wb_err || !wb_ack;
                        if (wb_ack && !wb_err && !r_we)
                            r_dat_r <= wb_dat_i;
                    end else begin
                        if ((r_state == S_REQ) && !wb_stall) begin
                            r_state <= S_WAIT;
                            r_stb   <= 1'b0;
                        end
                        if (r_wd != '1)
                            r_wd <= r_wd + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_busy  = r_busy;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign cpu_dat_r = r_dat_r;
    assign wb_cyc    = r_cyc;
    assign wb_stb    = r_stb;
    assign wb_we     = r_we;
    assign wb_adr    = r_adr;
    assign wb_dat_o  = r_dat_o;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master: scripted RAM slave with stall/latency knobs on the main instance,
// plus a TIMEOUT=8 instance driven by hand for watchdog and late-ack cases.
module tb_wb_cpu_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, cpu_busy, cpu_done, cpu_err;
    logic [15:0] cpu_adr, cpu_dat_w, cpu_dat_r;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
    logic [15:0] wb_adr, wb_dat_o, wb_dat_i;

    logic        t_req, t_we, t_busy, t_done, t_err;
    logic [15:0] t_adr, t_dat_w, t_dat_r;
    logic        t_cyc, t_stb, t_wwe, t_ack, t_werr, t_stall;
    logic [15:0] t_wadr, t_dat_o, t_dat_i;

    wb_cpu_master u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_dat_w(cpu_dat_w),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_dat_r(cpu_dat_r),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
    );

    wb_cpu_master #(.TIMEOUT(8)) u_to (
        .clk(clk), .rst(rst),
        .cpu_req(t_req), .cpu_we(t_we), .cpu_adr(t_adr), .cpu_dat_w(t_dat_w),
        .cpu_busy(t_busy), .cpu_done(t_done), .cpu_err(t_err), .cpu_dat_r(t_dat_r),
        .wb_cyc(t_cyc), .wb_stb(t_stb), .wb_we(t_wwe), .wb_adr(t_wadr), .wb_dat_o(t_dat_o),
        .wb_dat_i(t_dat_i), .wb_ack(t_ack), .wb_err(t_werr), .wb_stall(t_stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave RAM: counts cycles since cyc rose; stalls the first s_stall_n, acks s_ack_after later.
    logic [15:0] mem [0:255];
    int          s_c, s_stall_n, s_ack_after;
    bit          s_sonack, s_errm, s_a;

    initial begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = 16'hDEAD;
        s_c = 0;
        forever begin
            @(negedge clk);
            if (wb_cyc) begin
                s_a      = (s_c == s_stall_n + s_ack_after);
                wb_ack   = s_a;
                wb_err   = s_a && s_errm;
                wb_stall = (s_c < s_stall_n) || (s_sonack && s_a);
                wb_dat_i = s_a ? mem[wb_adr[7:0]] : 16'hDEAD;
                if (s_a && wb_we && !s_errm)
                    mem[wb_adr[7:0]] = wb_dat_o;
                s_c++;
            end else begin
                wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = 16'hDEAD;
                s_c = 0;
            end
        end
    end

    // Scoreboard entries are {cpu_err, cpu_dat_r} expected at each cpu_done.
    logic [16:0] sb [$];
    logic [16:0] sb_e;
    logic [15:0] exp_mem [0:255];
    logic [15:0] exp_last;
    int          done_total = 0;
    int          n_txn = 0;

    always @(negedge clk) begin
        if (cpu_done) begin
            done_total++;
            check("done_not_busy", cpu_busy, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", cpu_done, 0);
            end else begin
                sb_e = sb.pop_front();
                check("done_err", cpu_err, sb_e[16]);
                check("done_dat", cpu_dat_r, sb_e[15:0]);
            end
        end
    end

    task automatic run_txn(input bit we, input logic [15:0] adr, input logic [15:0] dat,
                           input int stall_n, input int ack_after, input bit sonack, input bit errm,
                           output int first_cyc, output int stb_cnt, output int cyc_cnt,
                           output int done_at, output int adr_bad);
        s_stall_n = stall_n; s_ack_after = ack_after; s_sonack = sonack; s_errm = errm;
        if (errm) begin
            sb.push_back({1'b1, exp_last});
        end else if (we) begin
            exp_mem[adr[7:0]] = dat;
            sb.push_back({1'b0, exp_last});
        end else begin
            exp_last = exp_mem[adr[7:0]];
            sb.push_back({1'b0, exp_last});
        end
        n_txn++;
        cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_dat_w = dat;
        first_cyc = -1; stb_cnt = 0; cyc_cnt = 0; done_at = -1; adr_bad = 0;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (wb_cyc) begin
                cyc_cnt++;
                if (first_cyc < 0) first_cyc = i;
                if (wb_adr !== adr || wb_we !== we || (we && wb_dat_o !== dat)) adr_bad++;
            end
            if (wb_stb) stb_cnt++;
            if (cpu_done) done_at = i;
        end
        check("txn_done_seen", done_at > 0, 1);
    endtask

    initial begin
        int fc, sc, cc, da, ab, done_before;
        cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_dat_w = 0;
        t_req = 0; t_we = 0; t_adr = 16'h0040; t_dat_w = 0;
        t_ack = 0; t_werr = 0; t_stall = 0; t_dat_i = 0;
        s_stall_n = 0; s_ack_after = 1; s_sonack = 0; s_errm = 0;
        for (int k = 0; k < 256; k++) begin
            mem[k] = 16'h0000;
            exp_mem[k] = 16'h0000;
        end
        mem[8'h12] = 16'hBEEF;
        exp_mem[8'h12] = 16'hBEEF;
        exp_last = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_cyc_stb", {wb_cyc, wb_stb, wb_we}, 0);
        check("rst_adr_dat", {wb_adr, wb_dat_o}, 0);
        check("rst_cpu_flags", {cpu_busy, cpu_done, cpu_err}, 0);
        check("rst_dat_r", cpu_dat_r, 0);
        check("rst_to_cyc", {t_cyc, t_stb, t_busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(0, 16'h0012, 16'h0, 1, 0, 1, 0, fc, sc, cc, da, ab);
        check("ref_first_cyc", fc, 1);
        check("ref_stb_cnt", sc, 2);
        check("ref_done_at", da, 3);
        check("ref_dat", cpu_dat_r, 16'hBEEF);

        run_txn(1, 16'h0034, 16'h1234, 0, 1, 0, 0, fc, sc, cc, da, ab);
        check("st_done_at", da, 3);
        check("st_stable", ab, 0);
        run_txn(0, 16'h0034, 16'h0, 0, 1, 0, 0, fc, sc, cc, da, ab);
        check("b2b_first_cyc", fc, 1);
        check("b2b_dat", cpu_dat_r, 16'h1234);

        run_txn(0, 16'h0012, 16'h0, 5, 3, 0, 0, fc, sc, cc, da, ab);
        check("stall_stb_cnt", sc, 6);
        check("stall_cyc_cnt", cc, 9);
        check("stall_adr_stable", ab, 0);
        check("stall_done_at", da, 10);

        run_txn(0, 16'h0034, 16'h0, 0, 1, 0, 1, fc, sc, cc, da, ab);
        check("errack_err", cpu_err, 1);
        check("errack_dat", cpu_dat_r, 16'hBEEF);

        @(negedge clk);
        s_stall_n = 0; s_ack_after = 6; s_sonack = 0; s_errm = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0012;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("pre_rst_wait", {wb_cyc, wb_stb, cpu_busy}, 3'b101);
        done_before = done_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idle", {wb_cyc, wb_stb, cpu_busy, cpu_done}, 0);
        repeat (8) @(negedge clk);
        check("mid_rst_no_done", done_total, done_before);
        check("mid_rst_dat_r", cpu_dat_r, 0);
        exp_last = 16'h0000;
        run_txn(0, 16'h0012, 16'h0, 1, 0, 1, 0, fc, sc, cc, da, ab);
        check("post_rst_done_at", da, 3);

        t_req = 1'b1;
        @(negedge clk);
        t_req = 1'b0;
        t_ack = 1'b1; t_dat_i = 16'h5A5A;
        @(negedge clk);
        t_ack = 1'b0; t_dat_i = 16'h0000;
        check("to_ok_done", {t_done, t_err}, 2'b10);
        check("to_ok_dat", t_dat_r, 16'h5A5A);
        t_req = 1'b1;
        cc = 0; da = -1;
        for (int i = 1; i <= 30 && da < 0; i++) begin
            @(negedge clk);
            t_req = 1'b0;
            if (t_cyc) cc++;
            if (t_done) da = i;
        end
        check("to_cyc_cnt", cc, 8);
        check("to_done_at", da, 9);
        check("to_err", t_err, 1);
        check("to_dat_kept", t_dat_r, 16'h5A5A);
        t_ack = 1'b1; t_dat_i = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_no_done", {t_done, t_cyc, t_busy}, 0);
        end
        t_ack = 1'b0;
        check("late_ack_dat", t_dat_r, 16'h5A5A);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("done_total", done_total, n_txn);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
